// File: rtl/mul_ko_pkg.sv
// Shared definitions for the one-level Karatsuba multiplier mul_ko_pipe.
//   state_e      - controller state encoding
//   half_w       - H = W/2, width of one operand half
//   sub_w        - H+1, width of one sub-multiplier operand (room for A+B carry)
//   lat_shared   - accept-to-valid latency with one shared sub-multiplier
//   lat_par      - accept-to-valid latency with three parallel sub-multipliers
//   wait_cycles  - cycles the controller sits in WAIT for a given mode
package mul_ko_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_COMB  = 3'd4,
    ST_FIN   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic int sub_w(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int lat_shared(input int l);
    return l + 5;
  endfunction

  function automatic int lat_par(input int l);
    return l + 3;
  endfunction

  // PRE, ISSUE, COMB and FIN each take exactly one edge; WAIT absorbs the rest.
  function automatic int wait_cycles(input int l, input bit par);
    return (par ? lat_par(l) : lat_shared(l)) - 4;
  endfunction

endpackage

// File: rtl/mul_ko_pipe_sub.sv
// mul_pipe_sub: unsigned N x N multiplier with an L-stage register pipeline.
// A product issued with vld_i high appears on p_o, with vld_o high for one
// cycle, L edges later; p_o holds its value until the next product arrives.
//   clk, rst_n  clock, asynchronous active-low reset
//   vld_i       issue strobe for a_i/b_i
//   a_i, b_i    N-bit unsigned operands
//   p_o         2N-bit registered product
//   vld_o       p_o was loaded on the last edge
module mul_pipe_sub #(
  parameter int N = 129,
  parameter int L = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vld_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic [2*N-1:0] p_o,
  output logic           vld_o
);

  logic [2*N-1:0] p_q [L];
  logic [L-1:0]   v_q;

  // NOTE: the pipeline array is reset like every other register here because
  // an abandoned operation must leave no stale product behind; this is not a
  // RAM, so the reset costs nothing in inference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < L; i++) p_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the value its
      // predecessor held before this edge, so loop order does not matter.
      v_q[0] <= vld_i;
      if (vld_i) p_q[0] <= {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
      for (int i = 1; i < L; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) p_q[i] <= p_q[i-1];
      end
    end
  end

  assign p_o   = p_q[L-1];
  assign vld_o = v_q[L-1];

endmodule

// File: rtl/mul_ko_pipe.sv
// mul_ko_pipe: W x W unsigned multiplier, one-level Karatsuba over H=W/2.
//   a = {A,B}, b = {C,D}; AC, BD and M=(A+B)(C+D) are (H+1)x(H+1) products;
//   r = AC<<W + (M-AC-BD)<<H + BD.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   vld_i / rdy_o  operand handshake; rdy_o is high only in IDLE
//   a_i, b_i       W-bit unsigned operands, sampled at the accept edge only
//   vld_o / rdy_i  result handshake; r_o held while vld_o && !rdy_i
//   r_o            2W-bit product
//   busy_o         high in every state except IDLE
// Build option: define MUL_KO_PIPE_PAR_EN for three parallel sub-multipliers
// (latency L+3); otherwise one shared sub-multiplier is used (latency L+5).
module mul_ko_pipe
  import mul_ko_pkg::*;
#(
  parameter int W = 256,
  parameter int L = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vld_i,
  output logic           rdy_o,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           vld_o,
  input  logic           rdy_i,
  output logic [2*W-1:0] r_o,
  output logic           busy_o
);

  localparam int H  = half_w(W);
  localparam int HP = sub_w(W);
  localparam int PW = 2 * HP;
`ifdef MUL_KO_PIPE_PAR_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int WC = wait_cycles(L, PAR);
  localparam int CW = $clog2(WC + 2);
  localparam logic [CW-1:0] WC_LAST = CW'((WC > 0) ? WC - 1 : 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [H-1:0]    a_hi_q, a_lo_q, b_hi_q, b_lo_q;
  logic [HP-1:0]   sa_q, sb_q;
  logic [PW-1:0]   mid_q;
  logic [2*W-1:0]  r_q;

  logic [PW-1:0]   ac_w, bd_w, m_w;
  logic [2*W-1:0]  r_sum;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // that no path leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (vld_i) state_d = ST_PRE;
      ST_PRE:   state_d = ST_ISSUE;
      ST_ISSUE: begin
        // With a single-cycle parallel multiplier the products are already
        // registered when ISSUE ends, so WAIT is skipped.
        if (WC == 0) begin
          state_d = ST_COMB;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WC_LAST;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_COMB;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_COMB:  state_d = ST_FIN;
      ST_FIN:   state_d = ST_DONE;
      ST_DONE:  if (rdy_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign rdy_o  = (state_q == ST_IDLE);
  assign busy_o = (state_q != ST_IDLE);
  assign vld_o  = (state_q == ST_DONE);
  assign r_o    = r_q;

  // --------------------------------------------------------------- datapath
  // Each term is zero-extended to 2W before shifting; mid never exceeds W+2
  // bits and the true product fits 2W bits, so the sum needs no wider carry.
  assign r_sum = ({{(W-2){1'b0}}, ac_w}  << W)
               + ({{(W-2){1'b0}}, mid_q} << H)
               +  {{(W-2){1'b0}}, bd_w};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_hi_q <= '0;
      a_lo_q <= '0;
      b_hi_q <= '0;
      b_lo_q <= '0;
      sa_q   <= '0;
      sb_q   <= '0;
      mid_q  <= '0;
      r_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (vld_i) begin
          {a_hi_q, a_lo_q} <= a_i;
          {b_hi_q, b_lo_q} <= b_i;
        end
        ST_PRE: begin
          sa_q <= {1'b0, a_hi_q} + {1'b0, a_lo_q};
          sb_q <= {1'b0, b_hi_q} + {1'b0, b_lo_q};
        end
        // M >= AC + BD always holds, so the W+2-bit difference is exact.
        ST_COMB: mid_q <= m_w - ac_w - bd_w;
        ST_FIN:  r_q   <= r_sum;
        default: ;
      endcase
    end
  end

`ifdef MUL_KO_PIPE_PAR_EN
  // ------------------------------------------- three parallel multipliers
  logic vld_ac, vld_bd, vld_m;
  logic issue;
  assign issue = (state_q == ST_ISSUE);

  mul_pipe_sub #(.N(HP), .L(L)) u_mul_ac (
    .clk(clk), .rst_n(rst_n), .vld_i(issue),
    .a_i({1'b0, a_hi_q}), .b_i({1'b0, b_hi_q}), .p_o(ac_w), .vld_o(vld_ac)
  );
  mul_pipe_sub #(.N(HP), .L(L)) u_mul_bd (
    .clk(clk), .rst_n(rst_n), .vld_i(issue),
    .a_i({1'b0, a_lo_q}), .b_i({1'b0, b_lo_q}), .p_o(bd_w), .vld_o(vld_bd)
  );
  mul_pipe_sub #(.N(HP), .L(L)) u_mul_m (
    .clk(clk), .rst_n(rst_n), .vld_i(issue),
    .a_i(sa_q), .b_i(sb_q), .p_o(m_w), .vld_o(vld_m)
  );

  // The WAIT counter already tracks the fixed latency, so the valid-outs
  // carry no extra information in this mode.
  logic unused_vld;
  assign unused_vld = vld_ac ^ vld_bd ^ vld_m;
`else
  // ----------------------------------------------- one shared multiplier
  // iss_q sequences the two issues following ISSUE (1: BD, 2: M); cap_q
  // routes returning products in the same order (0: AC, 1: BD, 2: M).
  logic [1:0]    iss_q, cap_q;
  logic          sub_vld, sub_vld_out;
  logic [HP-1:0] sub_a, sub_b;
  logic [PW-1:0] sub_p, ac_q, bd_q;

  always_comb begin
    sub_vld = (state_q == ST_ISSUE) || (iss_q != 2'd0);
    sub_a   = {1'b0, a_hi_q};
    sub_b   = {1'b0, b_hi_q};
    if (iss_q == 2'd1) begin
      sub_a = {1'b0, a_lo_q};
      sub_b = {1'b0, b_lo_q};
    end else if (iss_q == 2'd2) begin
      sub_a = sa_q;
      sub_b = sb_q;
    end
  end

  mul_pipe_sub #(.N(HP), .L(L)) u_mul (
    .clk(clk), .rst_n(rst_n), .vld_i(sub_vld),
    .a_i(sub_a), .b_i(sub_b), .p_o(sub_p), .vld_o(sub_vld_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q <= 2'd0;
      cap_q <= 2'd0;
      ac_q  <= '0;
      bd_q  <= '0;
    end else begin
      if (state_q == ST_ISSUE) iss_q <= 2'd1;
      else if (iss_q == 2'd1)  iss_q <= 2'd2;
      else                     iss_q <= 2'd0;

      if (sub_vld_out) begin
        case (cap_q)
          2'd0:    begin ac_q <= sub_p; cap_q <= 2'd1; end
          2'd1:    begin bd_q <= sub_p; cap_q <= 2'd2; end
          // M is the last product and stays in the multiplier's output
          // register through COMB, so it needs no copy.
          default: cap_q <= 2'd0;
        endcase
      end
    end
  end

  assign ac_w = ac_q;
  assign bd_w = bd_q;
  assign m_w  = sub_p;
`endif

endmodule

// File: tb/tb_mul_ko_pipe.sv
// Self-checking bench for mul_ko_pipe (W=256, L=4). Expected products come
// from a scoreboard queue filled by a direct 512-bit multiply when operands
// are accepted. Works for either setting of MUL_KO_PIPE_PAR_EN.
module tb_mul_ko_pipe;

  localparam int W = 256;
  localparam int L = 4;
`ifdef MUL_KO_PIPE_PAR_EN
  localparam int EXP_LAT = L + 3;
`else
  localparam int EXP_LAT = L + 5;
`endif

  logic           clk = 1'b0;
  logic           rst_n, vld_i, rdy_o, vld_o, rdy_i, busy_o;
  logic [W-1:0]   a_i, b_i;
  logic [2*W-1:0] r_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  mul_ko_pipe #(.W(W), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .rdy_o(rdy_o),
    .a_i(a_i), .b_i(b_i), .vld_o(vld_o), .rdy_i(rdy_i),
    .r_o(r_o), .busy_o(busy_o)
  );

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int j = 0; j < W / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair at a negedge, push its product, and scramble the
  // inputs right after the accept edge so late sampling would be visible.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (rdy_o !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rdy_before_accept", {511'b0, rdy_o}, 1);
    a_i   = a;
    b_i   = b;
    vld_i = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    vld_i = 1'b0;
    a_i   = ~a;
    b_i   = rand_w();
  endtask

  // k counts edges after the accept edge; vld_o seen at the negedge after
  // edge k means the latency is k.
  task automatic wait_result(input string tag);
    int k;
    logic [2*W-1:0] exp;
    k = 0;
    @(negedge clk);
    while (vld_o !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, EXP_LAT);
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_product"}, r_o, exp);
  endtask

  // Hold rdy_i low for 'stall' cycles (optionally poking vld_i with other
  // operands), then release and confirm the return to IDLE.
  task automatic finish_op(input string tag, input int stall, input bit poke);
    logic [2*W-1:0] held;
    held  = r_o;
    rdy_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        vld_i = 1'b1;
        a_i   = rand_w();
        b_i   = rand_w();
      end
      @(negedge clk);
      check({tag, "_stall_vld"}, {511'b0, vld_o}, 1);
      check({tag, "_stall_r"}, r_o, held);
    end
    vld_i = 1'b0;
    rdy_i = 1'b1;
    @(negedge clk);
    rdy_i = 1'b0;
    check({tag, "_idle_rdy"}, {511'b0, rdy_o}, 1);
    check({tag, "_idle_vld"}, {511'b0, vld_o}, 0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit poke);
    start_op(a, b);
    wait_result(tag);
    finish_op(tag, stall, poke);
  endtask

  initial begin
    logic [W-1:0] maxv, top, three;
    int seen;

    maxv  = '1;
    top   = '0;
    top[W-1] = 1'b1;
    three = W'(3);

    rst_n = 1'b0;
    vld_i = 1'b0;
    rdy_i = 1'b0;
    a_i   = '0;
    b_i   = '0;
    #2;
    check("reset_rdy",  {511'b0, rdy_o},  1);
    check("reset_vld",  {511'b0, vld_o},  0);
    check("reset_busy", {511'b0, busy_o}, 0);
    check("reset_r",    r_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All-ones operands (every half at its maximum, so A+B carries), with a
    // 10-cycle stall and ignored vld_i pokes while the result is held.
    start_op(maxv, maxv);
    wait_result("max");
    check("max_hi", {256'b0, r_o[2*W-1:W]}, {256'b0, maxv - W'(1)});
    check("max_lo", {256'b0, r_o[W-1:0]},   1);
    finish_op("max", 10, 1'b1);
    // Nothing more may come out after the ignored pokes.
    seen = 0;
    repeat (EXP_LAT + 4) begin
      @(negedge clk);
      if (vld_o === 1'b1) seen = 1;
    end
    check("no_duplicate", seen, 0);

    run_op("zero", '0, maxv, 0, 1'b0);
    check("zero_const", r_o, 0);
    run_op("top_x3", top, three, 2, 1'b0);
    run_op("x3_top", three, top, 1, 1'b0);
    run_op("one_one", W'(1), W'(1), 0, 1'b0);

    // Reset while waiting on the sub-multiplier(s).
    start_op(rand_w(), rand_w());
    repeat (4) @(negedge clk);
    check("rst_mid_busy", {511'b0, busy_o}, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_vld",  {511'b0, vld_o},  0);
    check("rst_mid_rdy",  {511'b0, rdy_o},  1);
    check("rst_mid_busy0", {511'b0, busy_o}, 0);
    check("rst_mid_r",    r_o, 0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (EXP_LAT + 10) begin
      @(negedge clk);
      if (vld_o === 1'b1) seen = 1;
    end
    check("rst_no_vld", seen, 0);
    run_op("after_rst", maxv, top, 0, 1'b0);

    // Random operands with random back-pressure; some halves forced to
    // all-ones to exercise the A+B / C+D carry.
    for (int n = 0; n < 120; n++) begin
      logic [W-1:0] a, b;
      a = rand_w();
      b = rand_w();
      if (n % 5 == 1) a[W/2-1:0] = '1;
      if (n % 7 == 2) b[W-1:W/2] = '1;
      run_op("rand", a, b, int'($urandom_range(0, 3)), 1'(n % 2));
    end

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_ko_pipe.md
MUL_KO_PIPE -- requirements
Module: mul_ko_pipe

Interface
REQ-001 Parameter W, default 256, operand width in bits; SHALL be even and >= 8.
REQ-002 Parameter L, default 4, sub-multiplier latency in cycles from issue to registered product; SHALL be >= 1.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 vld_i  input  1  operand pair valid.
REQ-006 rdy_o  output  1  block can accept operands.
REQ-007 a_i  input  W  multiplicand, unsigned.
REQ-008 b_i  input  W  multiplier, unsigned.
REQ-009 vld_o  output  1  product valid.
REQ-010 rdy_i  input  1  consumer accepts product.
REQ-011 r_o  output  2W  product a*b, unsigned.
REQ-012 busy_o  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL compute a*b by one-level Karatsuba with H=W/2:
- a={A,B}, b={C,D};
- products AC, BD, M=(A+B)(C+D), each (H+1)x(H+1) bits, exact with no carry correction;
- r = AC<<W + (M-AC-BD)<<H + BD, full 2W-bit result, no truncation.
REQ-014 Accept: a transfer SHALL occur on a clock edge with vld_i && rdy_o; rdy_o SHALL equal (state==IDLE).
REQ-015 The block SHALL have states IDLE, PRE, ISSUE, WAIT, COMB, FIN and DONE.
REQ-016 IDLE->PRE on accept; the edge SHALL register A,B,C,D.
REQ-017 PRE: register A+B and C+D (H+1 bits each).
REQ-018 ISSUE: issue the products to the sub-multiplier(s) per REQ-026/027.
REQ-019 WAIT: count until the last product is registered.
REQ-020 COMB: register mid=M-AC-BD (W+2 bits, never negative).
REQ-021 FIN: register r_o; DONE SHALL be entered on the next edge.
REQ-022 DONE: vld_o=1, and r_o SHALL be held stable until an edge with rdy_i=1, then the block SHALL go to IDLE.
REQ-023 Latency, accept edge to first edge with vld_o=1:
- L+5 cycles shared mode;
- L+3 cycles parallel mode.
REQ-024 vld_i while not in IDLE SHALL be ignored; operands SHALL not be captured.
REQ-025 a_i/b_i SHALL only be sampled at the accept edge; later changes SHALL not affect r_o.

Configuration
REQ-026 Macro MUL_KO_PIPE_PAR_EN defined -> three sub-multiplier instances, all products issued in the single ISSUE cycle, latency L+3.
REQ-027 MUL_KO_PIPE_PAR_EN undefined -> one shared sub-multiplier with L-deep pipelining:
- AC, BD and M SHALL be issued on three consecutive cycles starting at ISSUE;
- products captured in that order;
- latency L+5.
REQ-028 Results SHALL be bit-identical in both modes.

Reset
REQ-029 rst_n low SHALL force, asynchronously:
- state=IDLE;
- vld_o=0, busy_o=0, rdy_o=1;
- r_o=0;
- all operand, product and intermediate registers to 0.
REQ-030 Reset mid-operation SHALL abandon the operation; no vld_o SHALL follow.
REQ-031 The first accept after deassertion SHALL be legal.

Structure
REQ-032 Package mul_ko_pkg SHALL hold the state encoding constants, the H=W/2 and H+1 width helpers, and the latency constants for both modes.
REQ-033 The block SHALL contain one sub-module, mul_pipe_sub: unsigned (H+1)x(H+1) multiplier with parameter L, an input valid, a registered output and a valid-out.
REQ-034 The block SHALL use no vendor IP.

Verification
REQ-035 a=b=2^256-1, W=256 -> r_o[511:256]=2^256-2, r_o[255:0]=1, vld_o at accept+L+5 (shared) or +L+3 (parallel).
REQ-036 a=0, b=2^256-1 -> r_o=0.
REQ-037 A=B=C=D=2^128-1 (A+B carry), repeat with a=2^255, b=3 -> exact 512-bit product, checked against a reference model.
REQ-038 rdy_i=0 for 10 cycles after vld_o rises -> r_o and vld_o stable; vld_i pulses in this window ignored; IDLE the cycle after rdy_i=1.
REQ-039 rst_n asserted in WAIT -> vld_o never rises; next op after deassertion gives a correct result.
REQ-040 10^4 random operand pairs, random rdy_i, W in {8,64,256}, L in {1,4}, both macro settings -> all results match the model, no lost or duplicate products.
